// File: rtl/seq_divider_pkg.sv
// Shared constants and types for the sequential restoring divider.
package seq_divider_pkg;

   // Default operand/result width.
   localparam int unsigned WIDTH_DEFAULT = 8;

   // Iteration counter width, large enough for the widest legal WIDTH (32).
   localparam int unsigned CNT_W = $clog2(32);

   // Controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, and keep the difference only when no borrow occurs.
module div_step #(
   parameter int unsigned WIDTH = 9
) (
   input  logic [WIDTH-1:0] prem,
   input  logic             dbit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] prem_next,
   output logic             qbit
);

   logic [WIDTH-1:0] shifted;
   logic [WIDTH:0]   diff;

   // Trial subtract and restore mux.
   always_comb begin
      // The top remainder bit is always clear after a restoring step, so it can be dropped.
      shifted   = {prem[WIDTH-2:0], dbit};
      diff      = {1'b0, shifted} - {1'b0, divisor};
      qbit      = ~diff[WIDTH];
      prem_next = qbit ? diff[WIDTH-1:0] : shifted;
   end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional build macro DIV0_ERR_EN: divide-by-zero skips the iterations,
// finishes one cycle after acceptance and raises div0_err.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
`ifdef DIV0_ERR_EN
   ,
   output logic             div0_err
`endif
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH:0]   prem_q;
   logic [WIDTH-1:0] dvd_q;      // dividend shifts out the top, quotient bits shift in below
   logic [WIDTH-1:0] dsor_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic [WIDTH:0]   step_prem;
   logic             step_qbit;
`ifdef DIV0_ERR_EN
   logic             div0_q;
`endif

   div_step #(
      .WIDTH (WIDTH + 1)
   ) u_step (
      .prem      (prem_q),
      .dbit      (dvd_q[WIDTH-1]),
      .divisor   ({1'b0, dsor_q}),
      .prem_next (step_prem),
      .qbit      (step_qbit)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start is only looked at in IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
`ifdef DIV0_ERR_EN
               state_d = (divisor == '0) ? FIN : RUN;
`else
               state_d = RUN;
`endif
            end
         end
         RUN: begin
            if (cnt_q == '0) begin
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status and result outputs.
   always_comb begin
      busy      = (state_q == RUN);
      done      = (state_q == FIN);
      quotient  = quotient_q;
      remainder = remainder_q;
`ifdef DIV0_ERR_EN
      div0_err  = div0_q;
`endif
   end

   // Operand capture, iteration datapath and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         prem_q      <= '0;
         dvd_q       <= '0;
         dsor_q      <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
`ifdef DIV0_ERR_EN
         div0_q      <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  dvd_q  <= dividend;
                  dsor_q <= divisor;
                  prem_q <= '0;
                  cnt_q  <= CNT_W'(WIDTH - 1);
`ifdef DIV0_ERR_EN
                  div0_q <= 1'b0;
                  if (divisor == '0) begin
                     quotient_q  <= '1;
                     remainder_q <= dividend;
                     div0_q      <= 1'b1;
                  end
`endif
               end
            end
            RUN: begin
               prem_q <= step_prem;
               dvd_q  <= {dvd_q[WIDTH-2:0], step_qbit};
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  quotient_q  <= {dvd_q[WIDTH-2:0], step_qbit};
                  remainder_q <= step_prem[WIDTH-1:0];
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
